run_ctrl: RTL and testbench

Run/halt controller generating the CPU clock enable for the SAP-2 core. It supports free-run, single-instruction step, host halt, N address breakpoints and a cycle-count timeout. It latches a halt cause so benches and the front panel can identify why the CPU stopped. It sits between the host/debug command interface and the core's clock-enable and status signals (halt, PC, instruction boundary).

---
 rtl/run_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_run_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// run_ctrl: run/halt controller producing the SAP-2 core clock enable.
// Supports free-run, single-instruction step, host halt, NUM_BP address
// breakpoints and a per-run cycle timeout. The reason for the last stop is
// latched in halt_cause_o.
//
// Ports:
//   clk, reset            clock, async active-low reset
//   cmd_valid/cmd_ready   command handshake (ready tied high)
//   cmd_op                0 NOP 1 RUN 2 STEP 3 HALT 4 SET_BP 5 CLR
//   cmd_addr/bp_idx/bp_en breakpoint write payload for SET_BP
//   pc_i, instr_boundary_i, cpu_halt_i   core status
//   timeout_limit_i       max enabled cycles per RUN/STEP (0 = unlimited)
//   clk_en_o, halted_o    core enable / halted status
//   halt_cause_o          0 NONE 1 HLT 2 BREAK 3 STEP 4 TIMEOUT 5 USER
//   bp_hit_idx_o          lowest breakpoint slot matched at last BREAK
//   cycle_count_o         enabled cycles since last RUN/STEP accept
//   cmd_err_o             one-cycle pulse for an illegal command

// One breakpoint channel: enable + address, compared against the live PC.
module run_ctrl_bp #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  clr,
  input  logic                  en_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  match
);
  logic                  en;
  logic [ADDR_WIDTH-1:0] addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en   <= 1'b0;
      addr <= '0;
    end else if (wr) begin
      en   <= en_in;
      addr <= addr_in;
    end else if (clr) begin
      en   <= 1'b0;
    end
  end

  assign match = en && (addr == pc);
endmodule

module run_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_BP     = 4,
  parameter int CYC_WIDTH  = 16,
  localparam int IDX_W     = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [IDX_W-1:0]      cmd_bp_idx,
  input  logic                  cmd_bp_en,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  instr_boundary_i,
  input  logic                  cpu_halt_i,
  input  logic [CYC_WIDTH-1:0]  timeout_limit_i,
  output logic                  clk_en_o,
  output logic                  halted_o,
  output logic [2:0]            halt_cause_o,
  output logic [IDX_W-1:0]      bp_hit_idx_o,
  output logic [CYC_WIDTH-1:0]  cycle_count_o,
  output logic                  cmd_err_o
);
  localparam logic [2:0] OP_NOP = 3'd0, OP_RUN = 3'd1, OP_STEP = 3'd2,
                         OP_HALT = 3'd3, OP_SET_BP = 3'd4, OP_CLR = 3'd5;
  localparam logic [2:0] C_NONE = 3'd0, C_HLT = 3'd1, C_BREAK = 3'd2,
                         C_STEP = 3'd3, C_TMO = 3'd4, C_USER = 3'd5;

  typedef enum logic [1:0] {S_HALTED, S_RUNNING, S_STEPPING} state_t;

  state_t state, state_nxt;
  logic   skip_bp;
  logic   active, halted, stop, go_ok, set_acc, clr_acc, err_nxt;
  logic   c_hlt, c_user, c_brk, c_step, c_tmo;
  logic   bp_any;
  logic [2:0]        stop_cause;
  logic [IDX_W-1:0]  bp_idx;
  logic [NUM_BP-1:0] bp_match, bp_wr;

  assign cmd_ready = 1'b1;
  assign halted    = (state == S_HALTED);
  assign active    = !halted;
  assign halted_o  = halted;
  assign set_acc   = halted && cmd_valid && (cmd_op == OP_SET_BP);
  assign clr_acc   = halted && cmd_valid && (cmd_op == OP_CLR);

  genvar k;
  generate
    for (k = 0; k < NUM_BP; k++) begin : g_bp
      assign bp_wr[k] = set_acc && (cmd_bp_idx == IDX_W'(k));
      run_ctrl_bp #(.ADDR_WIDTH(ADDR_WIDTH)) u_bp (
        .clk(clk), .reset(reset), .wr(bp_wr[k]), .clr(clr_acc),
        .en_in(cmd_bp_en), .addr_in(cmd_addr), .pc(pc_i), .match(bp_match[k])
      );
    end
  endgenerate

  // Lowest matching slot wins: scan high to low so lower k overwrites.
  always_comb begin
    bp_any = |bp_match;
    bp_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--)
      if (bp_match[i]) bp_idx = IDX_W'(i);
  end

  // Stop is purely combinational so the gated edge never reaches the core.
  assign c_hlt  = active && cpu_halt_i;
  assign c_user = active && cmd_valid && (cmd_op == OP_HALT);
  assign c_brk  = active && instr_boundary_i && !skip_bp && bp_any;
  assign c_step = (state == S_STEPPING) && instr_boundary_i && !skip_bp;
  assign c_tmo  = active && (timeout_limit_i != '0) &&
                  (cycle_count_o == timeout_limit_i);
  assign stop   = c_hlt || c_user || c_brk || c_step || c_tmo;
  assign go_ok  = halted && cmd_valid && !cpu_halt_i &&
                  ((cmd_op == OP_RUN) || (cmd_op == OP_STEP));

  always_comb begin
    stop_cause = C_NONE;
    if      (c_hlt)  stop_cause = C_HLT;
    else if (c_user) stop_cause = C_USER;
    else if (c_brk)  stop_cause = C_BREAK;
    else if (c_step) stop_cause = C_STEP;
    else if (c_tmo)  stop_cause = C_TMO;
  end

  always_comb begin
    err_nxt = 1'b0;
    if (cmd_valid) begin
      case (cmd_op)
        OP_NOP, OP_HALT:    err_nxt = 1'b0;
        OP_RUN, OP_STEP:    err_nxt = active || cpu_halt_i;
        OP_SET_BP, OP_CLR:  err_nxt = active;
        default:            err_nxt = 1'b1;
      endcase
    end
  end

  // FSM: next state and clock enable.
  always_comb begin
    state_nxt = state;
    clk_en_o  = 1'b0;
    case (state)
      S_HALTED: begin
        if (go_ok) state_nxt = (cmd_op == OP_RUN) ? S_RUNNING : S_STEPPING;
      end
      S_RUNNING, S_STEPPING: begin
        clk_en_o = !stop;
        if (stop) state_nxt = S_HALTED;
      end
      default: state_nxt = S_HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_HALTED;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halt_cause_o  <= C_NONE;
      bp_hit_idx_o  <= '0;
      cycle_count_o <= '0;
      cmd_err_o     <= 1'b0;
      skip_bp       <= 1'b0;
    end else begin
      cmd_err_o <= err_nxt;
      if (go_ok) begin
        cycle_count_o <= '0;
        halt_cause_o  <= C_NONE;
        skip_bp       <= 1'b1;
      end else if (clr_acc) begin
        halt_cause_o <= C_NONE;
      end else if (active && stop) begin
        halt_cause_o <= stop_cause;
        if (stop_cause == C_BREAK) bp_hit_idx_o <= bp_idx;
      end
      if (clk_en_o) begin
        if (cycle_count_o != '1) cycle_count_o <= cycle_count_o + 1'b1;
        if (instr_boundary_i)    skip_bp <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed scenarios followed by random
// command/core-status traffic, all checked cycle by cycle against a
// behavioural model of the run/halt rules.
module tb_run_ctrl;
  localparam int AW = 8, NB = 4, CW = 4, IW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_bp_en;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_addr, pc_i;
  logic [IW-1:0] cmd_bp_idx, bp_hit_idx_o;
  logic          instr_boundary_i, cpu_halt_i;
  logic [CW-1:0] timeout_limit_i, cycle_count_o;
  logic          clk_en_o, halted_o, cmd_err_o;
  logic [2:0]    halt_cause_o;

  run_ctrl #(.ADDR_WIDTH(AW), .NUM_BP(NB), .CYC_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_bp_idx(cmd_bp_idx),
    .cmd_bp_en(cmd_bp_en), .pc_i(pc_i), .instr_boundary_i(instr_boundary_i),
    .cpu_halt_i(cpu_halt_i), .timeout_limit_i(timeout_limit_i),
    .clk_en_o(clk_en_o), .halted_o(halted_o), .halt_cause_o(halt_cause_o),
    .bp_hit_idx_o(bp_hit_idx_o), .cycle_count_o(cycle_count_o),
    .cmd_err_o(cmd_err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model
  bit m_run, m_step, m_skip, m_err;
  int m_cause, m_idx, m_cnt;
  bit bp_en[NB];
  int bp_addr[NB];
  bit obs_en;

  function automatic void model_reset();
    m_run = 0; m_step = 0; m_skip = 0; m_err = 0;
    m_cause = 0; m_idx = 0; m_cnt = 0;
    for (int k = 0; k < NB; k++) begin bp_en[k] = 0; bp_addr[k] = 0; end
  endfunction

  // Called at posedge+1 with inputs already driven; checks then advances.
  task automatic step();
    bit act, exp_en, is_cmd_ok;
    int hit, c;
    act = m_run || m_step;
    hit = -1;
    for (int k = 0; k < NB; k++)
      if (hit < 0 && bp_en[k] && bp_addr[k] == int'(pc_i)) hit = k;
    c = 0;
    if (act) begin
      if (cpu_halt_i)                                   c = 1;
      else if (cmd_valid && cmd_op == 3)                c = 5;
      else if (instr_boundary_i && !m_skip && hit >= 0) c = 2;
      else if (m_step && instr_boundary_i && !m_skip)   c = 3;
      else if (timeout_limit_i != 0 && m_cnt == int'(timeout_limit_i)) c = 4;
    end
    exp_en = act && (c == 0);
    #1;
    obs_en = clk_en_o;
    chk("clk_en", 32'(clk_en_o), 32'(exp_en));
    chk("halted", 32'(halted_o), 32'(!act));
    chk("cause", 32'(halt_cause_o), m_cause);
    chk("bp_idx", 32'(bp_hit_idx_o), m_idx);
    chk("cycles", 32'(cycle_count_o), m_cnt);
    chk("cmd_err", 32'(cmd_err_o), 32'(m_err));
    m_err = 0;
    if (act) begin
      is_cmd_ok = (cmd_op == 0) || (cmd_op == 3);
      if (cmd_valid && !is_cmd_ok) m_err = 1;
      if (c != 0) begin
        m_run = 0; m_step = 0; m_cause = c;
        if (c == 2) m_idx = hit;
      end else begin
        if (m_cnt < CMAX) m_cnt++;
        if (instr_boundary_i) m_skip = 0;
      end
    end else if (cmd_valid) begin
      case (cmd_op)
        1, 2: if (cpu_halt_i) m_err = 1;
              else begin
                m_run = (cmd_op == 1); m_step = (cmd_op == 2);
                m_cnt = 0; m_cause = 0; m_skip = 1;
              end
        4: begin bp_en[cmd_bp_idx] = cmd_bp_en; bp_addr[cmd_bp_idx] = int'(cmd_addr); end
        5: begin for (int k = 0; k < NB; k++) bp_en[k] = 0; m_cause = 0; end
        6, 7: m_err = 1;
        default: ;
      endcase
    end
    @(posedge clk); #1;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [AW-1:0] a, input logic [IW-1:0] i, input logic e);
    cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_bp_idx = i; cmd_bp_en = e;
    step();
    cmd_valid = 0; cmd_op = 0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 9) == 0) ? {AW{1'b1}} : AW'($urandom_range(0, 7));
  endfunction

  initial begin
    int n_en;
    reset = 0; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_bp_idx = 0;
    cmd_bp_en = 0; pc_i = 0; instr_boundary_i = 0; cpu_halt_i = 0;
    timeout_limit_i = 0;
    model_reset();
    #12;
    chk("rst_halted", 32'(halted_o), 1);
    chk("rst_clk_en", 32'(clk_en_o), 0);
    chk("rst_cause", 32'(halt_cause_o), 0);
    chk("rst_idx", 32'(bp_hit_idx_o), 0);
    chk("rst_cycles", 32'(cycle_count_o), 0);
    chk("rst_err", 32'(cmd_err_o), 0);
    reset = 1;
    @(posedge clk); #1;

    // Timeout: limit 10 gives exactly 10 enabled cycles.
    timeout_limit_i = 10;
    cmd(3'd1, 0, 0, 0);
    n_en = 0;
    for (int t = 0; t < 30; t++) begin step(); n_en += int'(obs_en); end
    chk("tmo_enabled", n_en, 10);
    chk("tmo_cause", 32'(halt_cause_o), 4);
    chk("tmo_cycles", 32'(cycle_count_o), 10);

    // User halt with no limit.
    timeout_limit_i = 0;
    cmd(3'd1, 0, 0, 0); step(); step();
    cmd(3'd3, 0, 0, 0);
    chk("user_cause", 32'(halt_cause_o), 5);

    // HLT and HALT together: HLT wins.
    cmd(3'd1, 0, 0, 0); step();
    cpu_halt_i = 1;
    cmd(3'd3, 0, 0, 0);
    chk("coinc_cause", 32'(halt_cause_o), 1);
    // RUN while core halted is illegal.
    cmd(3'd1, 0, 0, 0);
    chk("run_hlt_err", 32'(cmd_err_o), 1);
    cpu_halt_i = 0;
    cmd(3'd7, 0, 0, 0);
    chk("op7_err", 32'(cmd_err_o), 1);
    step();
    chk("err_pulse", 32'(cmd_err_o), 0);

    // Breakpoints: duplicate address, lowest slot reported, then STEP.
    cmd(3'd5, 0, 0, 0);
    cmd(3'd4, 8'h05, 2'd1, 1);
    cmd(3'd4, 8'h05, 2'd3, 1);
    cmd(3'd1, 0, 0, 0);
    pc_i = 8'h04; instr_boundary_i = 1; step();
    pc_i = 8'h05; step();
    chk("bp_cause", 32'(halt_cause_o), 2);
    chk("bp_slot", 32'(bp_hit_idx_o), 1);
    cmd(3'd2, 0, 0, 0);
    step();
    pc_i = 8'h06; step();
    chk("step_cause", 32'(halt_cause_o), 3);

    // SET_BP while running is rejected.
    instr_boundary_i = 0;
    cmd(3'd1, 0, 0, 0);
    cmd(3'd4, 8'h01, 2'd0, 1);
    chk("setbp_run_err", 32'(cmd_err_o), 1);

    // Async reset mid-run drops clk_en immediately and clears breakpoints.
    step();
    #2 reset = 0;
    #1;
    chk("arst_clk_en", 32'(clk_en_o), 0);
    chk("arst_halted", 32'(halted_o), 1);
    model_reset();
    @(posedge clk); #1;
    reset = 1;
    cmd(3'd1, 0, 0, 0);
    pc_i = 8'h05; instr_boundary_i = 1; step(); step();
    chk("arst_bp_clr", 32'(halted_o), 0);
    cmd(3'd3, 0, 0, 0);

    // Random traffic.
    for (int t = 0; t < 3000; t++) begin
      int r;
      if ($urandom_range(0, 49) == 0)
        timeout_limit_i = ($urandom_range(0, 1) == 0) ? '0 : CW'($urandom_range(1, CMAX));
      cmd_valid = ($urandom_range(0, 9) < 3);
      r = $urandom_range(0, 15);
      cmd_op = (r < 2) ? 3'd0 : (r < 6) ? 3'd1 : (r < 8) ? 3'd2 : (r < 10) ? 3'd3 :
               (r < 13) ? 3'd4 : (r < 14) ? 3'd5 : 3'(6 + (r & 1));
      cmd_addr = rnd_addr();
      cmd_bp_idx = IW'($urandom_range(0, NB - 1));
      cmd_bp_en = ($urandom_range(0, 3) != 0);
      pc_i = rnd_addr();
      instr_boundary_i = ($urandom_range(0, 4) < 2);
      cpu_halt_i = ($urandom_range(0, 24) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
